uart_apb_if: RTL and testbench
==============================

UART_APB_IF -- requirements
Module: uart_apb_if

Interface
REQ-001 Parameter DIV_RESET, default 16'd325, is the reset value of the divisor register (9600 baud at 50 MHz).
REQ-002 clk  in  1  single clock; all state SHALL be updated on its rising edge.
REQ-003 rst_n  in  1  asynchronous, active-low reset.
REQ-004 i_psel, i_penable, i_pwrite  in  1 each  APB select, enable and write strobes.
REQ-005 i_paddr  in  4  byte address: 0x0 DATA, 0x4 STATUS, 0x8 CTRL, 0xC DIV.
REQ-006 i_pwdata  in  32  write data; o_prdata  out  32  read data.
REQ-007 o_pready, o_pslverr  out  1 each  APB ready and error.
REQ-008 o_divisor  out  16; o_num_bit_data  out  2; o_parity_en, o_parity_type  out  1 each  UART configuration.
REQ-009 o_cpu_txd  out  8, o_tx_wr  out  1, i_tx_full  in  1  TX FIFO write port.
REQ-010 i_cpu_rxd  in  8  first-word-fall-through RX head; o_rx_rd  out  1; i_rx_empty, i_parity_err  in  1 each.
REQ-011 o_irq  out  1  level interrupt.

Function
REQ-012 The FSM SHALL have three states: IDLE, WAIT and DONE.
REQ-013 IDLE->WAIT on i_psel&i_penable; WAIT->DONE unconditionally; DONE->IDLE unconditionally.
REQ-014 In WAIT, if i_psel drops, the FSM SHALL go to IDLE with no side effects.
REQ-015 o_pready SHALL be 1 only in DONE, giving exactly one wait state per access.
REQ-016 o_prdata and o_pslverr SHALL be registered on the WAIT->DONE edge and held valid during DONE; o_prdata SHALL be 0 outside DONE.
REQ-017 All register side effects SHALL occur on the single clk edge that enters DONE.
REQ-018 An address with i_paddr[1:0]!=0 SHALL give o_pslverr=1, no side effect and o_prdata=0.
REQ-019 DATA write with i_tx_full=0: o_cpu_txd<=i_pwdata[7:0] and o_tx_wr pulses for exactly one cycle.
REQ-020 DATA write with i_tx_full=1: no o_tx_wr, o_pslverr=1, and sticky TX_OVF is set.
REQ-021 DATA read with i_rx_empty=0: o_prdata={24'b0,i_cpu_rxd} and o_rx_rd pulses for one cycle.
REQ-022 DATA read with i_rx_empty=1: o_prdata=0, o_pslverr=1 and no pop.
REQ-023 STATUS read SHALL return {28'b0, TX_OVF, PERR, i_tx_full, i_rx_empty} in bits [3:0].
REQ-024 STATUS write SHALL be write-1-to-clear on bits [3:2]; writes to other bits SHALL be ignored.
REQ-025 PERR SHALL be set on the rising edge of i_parity_err (previous-cycle sample is 0, current is 1).
REQ-026 If a sticky set and a W1C occur in the same cycle, the set SHALL win.
REQ-027 CTRL bits [1:0] num_bits, [2] parity_en, [3] parity_type, [4] irq_rx_en, [5] irq_err_en SHALL be read/write; other bits read as 0.
REQ-028 DIV bits [15:0] SHALL be read/write, and a written value of 0 SHALL be stored as 1.
REQ-029 o_irq SHALL be registered as (irq_rx_en & ~i_rx_empty) | (irq_err_en & (PERR|TX_OVF)), i.e. one cycle after its inputs.
REQ-030 Config outputs SHALL be driven directly from the register flops, so a new value is visible in the cycle after DONE is entered.
REQ-031 Back-to-back transfers SHALL be accepted, with a new transfer starting in the cycle after DONE.

Reset
REQ-032 rst_n low SHALL immediately force the FSM to IDLE and set o_pready=0, o_pslverr=0, o_prdata=0, o_tx_wr=0, o_rx_rd=0, o_irq=0, o_cpu_txd=0.
REQ-033 rst_n low SHALL immediately set o_divisor=DIV_RESET, o_num_bit_data=2'b11, o_parity_en=0, o_parity_type=0, irq enables=0, PERR=0 and TX_OVF=0.
REQ-034 Reset during WAIT or DONE SHALL abort the transfer, and no pulse SHALL be emitted after reset release.

Verification
REQ-035 Write DIV=0x00A2, then read DIV -> o_prdata=0x000000A2, o_divisor=0x00A2, pready high 2 cycles after access start.
REQ-036 Write DATA=0x5A with i_tx_full=0 -> o_cpu_txd=0x5A and one-cycle o_tx_wr; repeat with i_tx_full=1 -> pslverr=1, STATUS=0x8 (TX_OVF set, RX not empty).
REQ-037 i_rx_empty=0, i_cpu_rxd=0xC3, read DATA -> o_prdata=0xC3 and one o_rx_rd pulse; with i_rx_empty=1 -> o_prdata=0, pslverr=1, no pop.
REQ-038 Pulse i_parity_err, set CTRL=0x20 -> o_irq=1; write STATUS=0x4 while i_parity_err rises again -> PERR remains 1.
REQ-039 Write DIV=0 -> read DIV returns 1; access with i_paddr=0x2 -> pslverr=1 and no state change.
REQ-040 Assert rst_n low during the WAIT state of a DATA write -> no o_tx_wr, all outputs at their REQ-032/REQ-033 reset values.

Source files
------------

// File: rtl/uart_apb_if.sv
// UART APB register block: one-wait-state APB slave
// exposing DATA/STATUS/CTRL/DIV and the UART config.
module uart_apb_if #(
  parameter logic [15:0] DIV_RESET = 16'd325
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_psel,
  input  logic        i_penable,
  input  logic        i_pwrite,
  input  logic [3:0]  i_paddr,
  input  logic [31:0] i_pwdata,
  output logic [31:0] o_prdata,
  output logic        o_pready,
  output logic        o_pslverr,
  output logic [15:0] o_divisor,
  output logic [1:0]  o_num_bit_data,
  output logic        o_parity_en,
  output logic        o_parity_type,
  output logic [7:0]  o_cpu_txd,
  output logic        o_tx_wr,
  input  logic        i_tx_full,
  input  logic [7:0]  i_cpu_rxd,
  output logic        o_rx_rd,
  input  logic        i_rx_empty,
  input  logic        i_parity_err,
  output logic        o_irq
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DONE
  } state_t;

  state_t      state;
  logic [15:0] div_q;
  logic [1:0]  nb_q;
  logic        pe_q;
  logic        pt_q;
  logic        irx_q;
  logic        ierr_q;
  logic        perr_q;
  logic        ovf_q;
  logic        par_q;

  logic        aligned;
  logic        sel_data;
  logic        sel_stat;
  logic        sel_ctrl;
  logic        sel_div;
  logic        commit;
  logic        ovf_set;
  logic        perr_set;
  logic        st_clr;
  logic [31:0] rd_val;
  logic        err_val;
  logic        unused_wdata;

  assign unused_wdata = ^i_pwdata[31:16];

  assign aligned  = i_paddr[1:0] == 2'b00;
  assign sel_data = aligned && i_paddr[3:2] == 2'd0;
  assign sel_stat = aligned && i_paddr[3:2] == 2'd1;
  assign sel_ctrl = aligned && i_paddr[3:2] == 2'd2;
  assign sel_div  = aligned && i_paddr[3:2] == 2'd3;

  assign commit   = state == WAIT && i_psel;
  assign ovf_set  = commit && sel_data
                 && i_pwrite && i_tx_full;
  assign perr_set = i_parity_err && !par_q;
  assign st_clr   = commit && sel_stat && i_pwrite;

  assign o_divisor      = div_q;
  assign o_num_bit_data = nb_q;
  assign o_parity_en    = pe_q;
  assign o_parity_type  = pt_q;

  always_comb begin
    rd_val  = '0;
    err_val = 1'b0;
    unique case (1'b1)
      !aligned: err_val = 1'b1;
      sel_data: begin
        if (i_pwrite) begin
          err_val = i_tx_full;
        end else if (i_rx_empty) begin
          err_val = 1'b1;
        end else begin
          rd_val = {24'b0, i_cpu_rxd};
        end
      end
      sel_stat: begin
        if (!i_pwrite)
          rd_val = {28'b0, ovf_q, perr_q,
                    i_tx_full, i_rx_empty};
      end
      sel_ctrl: begin
        if (!i_pwrite)
          rd_val = {26'b0, ierr_q, irx_q,
                    pt_q, pe_q, nb_q};
      end
      sel_div: begin
        if (!i_pwrite)
          rd_val = {16'b0, div_q};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      o_pready  <= 1'b0;
      o_pslverr <= 1'b0;
      o_prdata  <= '0;
      o_tx_wr   <= 1'b0;
      o_rx_rd   <= 1'b0;
      o_irq     <= 1'b0;
      o_cpu_txd <= '0;
      div_q     <= DIV_RESET;
      nb_q      <= 2'b11;
      pe_q      <= 1'b0;
      pt_q      <= 1'b0;
      irx_q     <= 1'b0;
      ierr_q    <= 1'b0;
      perr_q    <= 1'b0;
      ovf_q     <= 1'b0;
      par_q     <= 1'b0;
    end else begin
      par_q  <= i_parity_err;
      o_irq  <= (irx_q && !i_rx_empty)
             || (ierr_q && (perr_q || ovf_q));
      // a sticky set beats a same-cycle clear
      ovf_q  <= ovf_set
             || (ovf_q && !(st_clr && i_pwdata[3]));
      perr_q <= perr_set
             || (perr_q && !(st_clr && i_pwdata[2]));
      o_tx_wr   <= 1'b0;
      o_rx_rd   <= 1'b0;
      o_pready  <= 1'b0;
      o_pslverr <= 1'b0;
      o_prdata  <= '0;
      case (state)
        IDLE: begin
          if (i_psel && i_penable)
            state <= WAIT;
        end
        WAIT: begin
          if (!i_psel) begin
            state <= IDLE;
          end else begin
            state     <= DONE;
            o_pready  <= 1'b1;
            o_prdata  <= rd_val;
            o_pslverr <= err_val;
            if (sel_data && i_pwrite && !i_tx_full) begin
              o_cpu_txd <= i_pwdata[7:0];
              o_tx_wr   <= 1'b1;
            end
            if (sel_data && !i_pwrite && !i_rx_empty)
              o_rx_rd <= 1'b1;
            if (sel_ctrl && i_pwrite)
              {ierr_q, irx_q, pt_q, pe_q, nb_q}
                <= i_pwdata[5:0];
            if (sel_div && i_pwrite)
              div_q <= (i_pwdata[15:0] == 16'd0)
                     ? 16'd1 : i_pwdata[15:0];
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_apb_if.sv
// Bench for uart_apb_if: transaction-level register
// model compared against the DUT on every cycle.
module tb_uart_apb_if;

  localparam logic [15:0] DIVR = 16'd325;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        i_psel = 1'b0;
  logic        i_penable = 1'b0;
  logic        i_pwrite = 1'b0;
  logic [3:0]  i_paddr = '0;
  logic [31:0] i_pwdata = '0;
  logic [31:0] o_prdata;
  logic        o_pready;
  logic        o_pslverr;
  logic [15:0] o_divisor;
  logic [1:0]  o_num_bit_data;
  logic        o_parity_en;
  logic        o_parity_type;
  logic [7:0]  o_cpu_txd;
  logic        o_tx_wr;
  logic        i_tx_full = 1'b0;
  logic [7:0]  i_cpu_rxd = '0;
  logic        o_rx_rd;
  logic        i_rx_empty = 1'b1;
  logic        i_parity_err = 1'b0;
  logic        o_irq;

  always #5 clk = ~clk;

  uart_apb_if #(.DIV_RESET(DIVR)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .i_psel(i_psel),
    .i_penable(i_penable),
    .i_pwrite(i_pwrite),
    .i_paddr(i_paddr),
    .i_pwdata(i_pwdata),
    .o_prdata(o_prdata),
    .o_pready(o_pready),
    .o_pslverr(o_pslverr),
    .o_divisor(o_divisor),
    .o_num_bit_data(o_num_bit_data),
    .o_parity_en(o_parity_en),
    .o_parity_type(o_parity_type),
    .o_cpu_txd(o_cpu_txd),
    .o_tx_wr(o_tx_wr),
    .i_tx_full(i_tx_full),
    .i_cpu_rxd(i_cpu_rxd),
    .o_rx_rd(o_rx_rd),
    .i_rx_empty(i_rx_empty),
    .i_parity_err(i_parity_err),
    .o_irq(o_irq)
  );

  int checks = 0;
  int errors = 0;
  int tx_cnt = 0;
  int rx_cnt = 0;
  bit rnd = 0;
  bit commit_next = 0;

  // register model
  logic [15:0] m_div;
  logic [1:0]  m_nb;
  logic        m_pe, m_pt, m_irx, m_ierr;
  logic        m_perr, m_ovf, m_parprev, m_irq;
  logic [7:0]  m_txd;
  logic        e_pready, e_err, e_txwr, e_rxrd;
  logic [31:0] e_prdata;

  function automatic void chk(string n,
      logic [31:0] a, logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %h want %h", n, a, e);
    end
  endfunction

  function automatic void model_reset();
    m_div = DIVR; m_nb = 2'b11;
    m_pe = 0; m_pt = 0; m_irx = 0; m_ierr = 0;
    m_perr = 0; m_ovf = 0; m_parprev = 0;
    m_irq = 0; m_txd = 0;
    e_pready = 0; e_err = 0; e_txwr = 0;
    e_rxrd = 0; e_prdata = 0;
    commit_next = 0;
  endfunction

  // effect of the coming rising edge
  function automatic void model_edge();
    logic irq_n, er, txw, rxr;
    logic [31:0] rd;
    if (!rst_n) begin
      model_reset();
    end else begin
      irq_n = (m_irx & ~i_rx_empty)
            | (m_ierr & (m_perr | m_ovf));
      rd = 0; er = 0; txw = 0; rxr = 0;
      if (commit_next) begin
        if (i_paddr[1:0] != 2'b00) er = 1;
        else case (i_paddr[3:2])
          2'd0: begin
            if (i_pwrite) begin
              if (i_tx_full) begin
                er = 1; m_ovf = 1;
              end else begin
                m_txd = i_pwdata[7:0]; txw = 1;
              end
            end else if (i_rx_empty) begin
              er = 1;
            end else begin
              rd = {24'b0, i_cpu_rxd}; rxr = 1;
            end
          end
          2'd1: begin
            if (i_pwrite) begin
              if (i_pwdata[3]) m_ovf = 0;
              if (i_pwdata[2]) m_perr = 0;
            end else begin
              rd = {28'b0, m_ovf, m_perr,
                    i_tx_full, i_rx_empty};
            end
          end
          2'd2: begin
            if (i_pwrite)
              {m_ierr, m_irx, m_pt, m_pe, m_nb}
                = i_pwdata[5:0];
            else
              rd = {26'b0, m_ierr, m_irx,
                    m_pt, m_pe, m_nb};
          end
          default: begin
            if (i_pwrite)
              m_div = (i_pwdata[15:0] == 0)
                    ? 16'd1 : i_pwdata[15:0];
            else
              rd = {16'b0, m_div};
          end
        endcase
      end
      if (i_parity_err && !m_parprev) m_perr = 1;
      m_parprev = i_parity_err;
      m_irq = irq_n;
      e_pready = commit_next;
      e_prdata = rd;
      e_err = er;
      e_txwr = txw;
      e_rxrd = rxr;
      commit_next = 0;
    end
  endfunction

  task automatic tick();
    model_edge();
    @(negedge clk);
    chk("pready", o_pready, e_pready);
    chk("prdata", o_prdata, e_prdata);
    chk("pslverr", o_pslverr, e_err);
    chk("tx_wr", o_tx_wr, e_txwr);
    chk("rx_rd", o_rx_rd, e_rxrd);
    chk("cpu_txd", o_cpu_txd, m_txd);
    chk("irq", o_irq, m_irq);
    chk("divisor", o_divisor, m_div);
    chk("num_bits", o_num_bit_data, m_nb);
    chk("parity_en", o_parity_en, m_pe);
    chk("parity_type", o_parity_type, m_pt);
    if (o_tx_wr) tx_cnt++;
    if (o_rx_rd) rx_cnt++;
    if (rnd) begin
      i_tx_full    = 1'($urandom_range(0, 1));
      i_rx_empty   = 1'($urandom_range(0, 1));
      i_cpu_rxd    = 8'($urandom);
      i_parity_err = ($urandom_range(0, 15) == 0);
    end
  endtask

  task automatic apb(input logic [3:0] a,
      input bit w, input logic [31:0] d,
      input bit par_rise,
      output logic [31:0] rdat, output logic err);
    i_psel = 1; i_penable = 0;
    i_paddr = a; i_pwrite = w; i_pwdata = d;
    tick();
    i_penable = 1;
    tick();
    if (par_rise) i_parity_err = 1;
    commit_next = 1;
    tick();
    rdat = o_prdata;
    err = o_pslverr;
    chk("pready_latency", o_pready, 1);
    i_psel = 0; i_penable = 0;
    tick();
  endtask

  task automatic check_reset_outs(string tag);
    chk({tag, "_pready"}, o_pready, 0);
    chk({tag, "_pslverr"}, o_pslverr, 0);
    chk({tag, "_prdata"}, o_prdata, 0);
    chk({tag, "_tx_wr"}, o_tx_wr, 0);
    chk({tag, "_rx_rd"}, o_rx_rd, 0);
    chk({tag, "_irq"}, o_irq, 0);
    chk({tag, "_txd"}, o_cpu_txd, 0);
    chk({tag, "_div"}, o_divisor, 16'd325);
    chk({tag, "_nb"}, o_num_bit_data, 2'b11);
    chk({tag, "_pe"}, o_parity_en, 0);
    chk({tag, "_pt"}, o_parity_type, 0);
  endtask

  logic [31:0] r;
  logic        e;
  int          c0;
  logic [3:0]  ra;
  logic [31:0] rd_d;

  initial begin
    model_reset();
    #1 rst_n = 0;
    #1 check_reset_outs("por");
    tick();
    tick();
    rst_n = 1;
    tick();

    // divisor write/read
    apb(4'hC, 1, 32'h0000_00A2, 0, r, e);
    apb(4'hC, 0, 0, 0, r, e);
    chk("div_read", r, 32'h0000_00A2);
    chk("div_out", o_divisor, 16'h00A2);

    // transmit, then overflow
    i_tx_full = 0; i_rx_empty = 0;
    c0 = tx_cnt;
    apb(4'h0, 1, 32'h5A, 0, r, e);
    chk("txd_5a", o_cpu_txd, 8'h5A);
    chk("tx_pulses", tx_cnt - c0, 1);
    i_tx_full = 1;
    apb(4'h0, 1, 32'hA5, 0, r, e);
    chk("ovf_err", e, 1);
    chk("ovf_no_wr", tx_cnt - c0, 1);
    i_tx_full = 0;
    apb(4'h4, 0, 0, 0, r, e);
    chk("status_ovf", r, 32'h8);

    // receive, then empty
    i_cpu_rxd = 8'hC3;
    c0 = rx_cnt;
    apb(4'h0, 0, 0, 0, r, e);
    chk("rx_data", r, 32'hC3);
    chk("rx_pops", rx_cnt - c0, 1);
    i_rx_empty = 1;
    apb(4'h0, 0, 0, 0, r, e);
    chk("rx_empty_data", r, 0);
    chk("rx_empty_err", e, 1);
    chk("rx_empty_pops", rx_cnt - c0, 1);

    // parity sticky, irq, set beats clear
    i_parity_err = 1; tick();
    i_parity_err = 0; tick();
    apb(4'h8, 1, 32'h20, 0, r, e);
    chk("irq_err", o_irq, 1);
    apb(4'h4, 1, 32'h4, 1, r, e);
    i_parity_err = 0;
    apb(4'h4, 0, 0, 0, r, e);
    chk("perr_set_wins", r[2], 1);

    // zero divisor and misaligned access
    apb(4'hC, 1, 0, 0, r, e);
    apb(4'hC, 0, 0, 0, r, e);
    chk("div_zero", r, 1);
    apb(4'h2, 1, 32'hFFFF_FFFF, 0, r, e);
    chk("misalign_err", e, 1);
    chk("misalign_div", o_divisor, 1);
    apb(4'h8, 0, 0, 0, r, e);
    chk("misalign_ctrl", r, 32'h20);
    apb(4'h6, 0, 0, 0, r, e);
    chk("misalign_rd", r, 0);

    // psel dropped in WAIT
    c0 = tx_cnt;
    i_psel = 1; i_penable = 0;
    i_paddr = 0; i_pwrite = 1; i_pwdata = 32'h99;
    tick();
    i_penable = 1; tick();
    i_psel = 0; i_penable = 0;
    tick(); tick();
    chk("abort_no_wr", tx_cnt - c0, 0);
    chk("abort_txd", o_cpu_txd, 8'h5A);

    // reset during WAIT of a DATA write
    c0 = tx_cnt;
    i_psel = 1; i_penable = 0;
    i_paddr = 0; i_pwrite = 1; i_pwdata = 32'h77;
    tick();
    i_penable = 1; tick();
    rst_n = 0;
    #1 check_reset_outs("rst_wait");
    i_psel = 0; i_penable = 0;
    tick(); tick();
    rst_n = 1;
    tick(); tick(); tick();
    chk("rst_no_wr", tx_cnt - c0, 0);
    apb(4'h4, 0, 0, 0, r, e);
    chk("rst_status", r, 32'h1);

    // randomized traffic
    rnd = 1;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 7) == 0)
        ra = 4'($urandom);
      else
        ra = {2'($urandom), 2'b00};
      rd_d = $urandom;
      if (ra == 4'hC && $urandom_range(0, 2) == 0)
        rd_d = 0;
      apb(ra, 1'($urandom), rd_d, 0, r, e);
    end
    rnd = 0;
    i_parity_err = 0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
